// File: rtl/minrv32_pkg.sv
// Shared types and constants for the minrv32 memory arbiter.
//   state_e : arbiter FSM states (IDLE, ACCESS, RESP)
//   grant_e : which requester owns the memory port (GNT_I fetch, GNT_D data)
//   TimeoutDefault : default limit on ACCESS cycles waiting for mem_ready
package minrv32_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  localparam int unsigned TimeoutDefault = 15;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  function automatic grant_e pick_grant(logic i_req, logic d_req, grant_e last);
    if (i_req && d_req) begin
      return (last == GNT_I) ? GNT_D : GNT_I;
    end else if (i_req) begin
      return GNT_I;
    end else begin
      return GNT_D;
    end
  endfunction

endpackage

// File: rtl/minrv32_mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data.
// Each transaction is IDLE (grant + latch) -> ACCESS (until mem_ready or timeout) -> RESP.
// Ports:
//   clock, resetn                  : clock (rising edge), async active-low reset
//   i_valid, i_addr                : fetch request (read only)
//   i_ready, i_err, i_rdata        : fetch response, ready pulses one cycle
//   d_valid, d_addr, d_wdata, d_wstrb : data request (wstrb == 0 is a read)
//   d_ready, d_err, d_rdata        : data response, ready pulses one cycle
//   mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb : shared memory request
//   mem_ready, mem_rdata           : memory response
//   trap                           : sticky timeout flag, cleared only by reset
module minrv32_mem_arbiter
  import minrv32_pkg::*;
#(
  parameter int unsigned TIMEOUT        = TimeoutDefault,
  parameter logic [31:0] PROGADDR_RESET = 32'h0001_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        trap
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Count value on the last ACCESS cycle allowed before a timeout.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e      state_q, state_d;
  grant_e      grant_q, grant_d;
  grant_e      last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        trap_q, trap_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_err_q, i_err_d;
  logic        d_err_q, d_err_d;
  grant_e      pick;

  assign pick = pick_grant(i_valid, d_valid, last_grant_q);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    cnt_d        = cnt_q;
    trap_d       = trap_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_err_d      = i_err_q;
    d_err_d      = d_err_q;

    unique case (state_q)
      IDLE: begin
        if (i_valid || d_valid) begin
          grant_d      = pick;
          last_grant_d = pick;
          cnt_d        = '0;
          state_d      = ACCESS;
          if (pick == GNT_I) begin
            // Fetches never write.
            addr_d  = i_addr;
            wdata_d = '0;
            wstrb_d = '0;
          end else begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            wstrb_d = d_wstrb;
          end
        end
      end
      ACCESS: begin
        // mem_ready takes priority over a timeout landing on the same cycle.
        if (mem_ready) begin
          state_d = RESP;
          if (grant_q == GNT_I) begin
            i_rdata_d = mem_rdata;
            i_err_d   = 1'b0;
          end else begin
            d_rdata_d = mem_rdata;
            d_err_d   = 1'b0;
          end
        end else if (cnt_q == CntLast) begin
          state_d = RESP;
          trap_d  = 1'b1;
          if (grant_q == GNT_I) begin
            i_rdata_d = '0;
            i_err_d   = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= GNT_I;
      last_grant_q <= GNT_D;
      addr_q       <= PROGADDR_RESET;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cnt_q        <= '0;
      trap_q       <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      cnt_q        <= cnt_d;
      trap_q       <= trap_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_err_q      <= i_err_d;
      d_err_q      <= d_err_d;
    end
  end

  // Outputs decode straight from the state register so reset drops them immediately.
  assign mem_valid = (state_q == ACCESS);
  assign mem_instr = mem_valid && (grant_q == GNT_I);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign i_ready   = (state_q == RESP) && (grant_q == GNT_I);
  assign d_ready   = (state_q == RESP) && (grant_q == GNT_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_err     = i_err_q;
  assign d_err     = d_err_q;
  assign trap      = trap_q;

endmodule

// File: tb/tb_minrv32_mem_arbiter.sv
// Self-checking bench for minrv32_mem_arbiter: directed scenarios plus a randomized run,
// all checked against a transaction-level reference model kept here.
module tb_minrv32_mem_arbiter;

  localparam int unsigned Timeout  = 15;
  localparam logic [31:0] ProgAddr = 32'h0001_0000;

  logic        clock = 1'b0;
  logic        resetn;
  logic        i_valid, d_valid;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        i_ready, i_err, d_ready, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_valid, mem_instr, mem_ready, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clock = ~clock;

  minrv32_mem_arbiter #(
    .TIMEOUT       (Timeout),
    .PROGADDR_RESET(ProgAddr)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .i_valid  (i_valid),
    .i_addr   (i_addr),
    .i_ready  (i_ready),
    .i_err    (i_err),
    .i_rdata  (i_rdata),
    .d_valid  (d_valid),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_ready  (d_ready),
    .d_err    (d_err),
    .d_rdata  (d_rdata),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .trap     (trap)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: the transaction currently owning the port (requester 0 = I, 1 = D).
  bit          t_live, t_done;
  int          t_who, t_nacc;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_wstrb;
  int          last_who;
  logic [31:0] e_rdata [2];
  bit          e_err   [2];
  bit          e_trap;

  // Requester and memory-side stimulus state.
  bit          rq_act [2];
  bit          rq_cool[2];
  logic [31:0] rq_addr[2];
  logic [31:0] d_wdata_v;
  logic [3:0]  d_wstrb_v;
  int          mem_force;
  int          mem_wait;
  int          acc_seen;
  bit          noise;
  bit          rdata_fix_en;
  logic [31:0] rdata_fix;

  // Observations.
  int          cyc;
  int          rdy_cnt[2];
  int          rdy_cyc[2];
  int          acc_obs;
  int          both_rdy;
  int          gnt_log[$];
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_wstrb;
  logic        obs_instr;

  task automatic model_reset();
    t_live     = 1'b0;
    t_done     = 1'b0;
    last_who   = 1;
    e_rdata[0] = '0;
    e_rdata[1] = '0;
    e_err[0]   = 1'b0;
    e_err[1]   = 1'b0;
    e_trap     = 1'b0;
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
    if (r == 6) return Timeout - 1;
    if (r == 7) return Timeout - 2;
    return 1000;
  endfunction

  task automatic request(input int who, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    rq_act[who]  = 1'b1;
    rq_addr[who] = addr;
    if (who == 1) begin
      d_wdata_v = wdata;
      d_wstrb_v = wstrb;
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, then advance the model.
  task automatic step();
    bit exp_acc, exp_resp, first_acc;
    int who;
    i_valid    = rq_act[0];
    d_valid    = rq_act[1];
    i_addr     = rq_addr[0];
    d_addr     = rq_addr[1];
    d_wdata    = d_wdata_v;
    d_wstrb    = d_wstrb_v;
    rq_cool[0] = 1'b0;
    rq_cool[1] = 1'b0;
    first_acc  = 1'b0;
    if (mem_valid) begin
      if (acc_seen == 0) begin
        mem_wait  = (mem_force >= 0) ? mem_force : pick_wait();
        first_acc = 1'b1;
      end
      mem_ready = (acc_seen == mem_wait);
      acc_seen++;
    end else begin
      acc_seen  = 0;
      mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    mem_rdata = rdata_fix_en ? rdata_fix : $urandom();

    exp_acc  = t_live && !t_done;
    exp_resp = t_live && t_done;

    @(negedge clock);
    check_eq("mem_valid", mem_valid, exp_acc);
    check_eq("mem_instr", mem_instr, exp_acc && (t_who == 0));
    if (exp_acc) begin
      check_eq("mem_addr", mem_addr, t_addr);
      check_eq("mem_wdata", mem_wdata, t_wdata);
      check_eq("mem_wstrb", mem_wstrb, t_wstrb);
    end
    check_eq("i_ready", i_ready, exp_resp && (t_who == 0));
    check_eq("d_ready", d_ready, exp_resp && (t_who == 1));
    check_eq("i_rdata", i_rdata, e_rdata[0]);
    check_eq("i_err", i_err, e_err[0]);
    check_eq("d_rdata", d_rdata, e_rdata[1]);
    check_eq("d_err", d_err, e_err[1]);
    check_eq("trap", trap, e_trap);

    if (mem_valid) begin
      acc_obs++;
      obs_addr  = mem_addr;
      obs_wdata = mem_wdata;
      obs_wstrb = mem_wstrb;
      obs_instr = mem_instr;
      if (first_acc) gnt_log.push_back(mem_instr ? 0 : 1);
    end
    if (i_ready && d_ready) both_rdy++;
    if (i_ready) begin
      rdy_cnt[0]++;
      rdy_cyc[0] = cyc;
      rq_act[0]  = 1'b0;
      rq_cool[0] = 1'b1;
    end
    if (d_ready) begin
      rdy_cnt[1]++;
      rdy_cyc[1] = cyc;
      rq_act[1]  = 1'b0;
      rq_cool[1] = 1'b1;
    end

    if (!t_live) begin
      if (i_valid || d_valid) begin
        who      = (i_valid && d_valid) ? (1 - last_who) : (i_valid ? 0 : 1);
        last_who = who;
        t_who    = who;
        t_live   = 1'b1;
        t_done   = 1'b0;
        t_nacc   = 0;
        t_addr   = (who == 0) ? i_addr : d_addr;
        t_wdata  = (who == 0) ? 32'h0 : d_wdata;
        t_wstrb  = (who == 0) ? 4'h0 : d_wstrb;
      end
    end else if (!t_done) begin
      t_nacc++;
      if (mem_ready) begin
        t_done         = 1'b1;
        e_rdata[t_who] = mem_rdata;
        e_err[t_who]   = 1'b0;
      end else if (t_nacc == Timeout) begin
        t_done         = 1'b1;
        e_rdata[t_who] = '0;
        e_err[t_who]   = 1'b1;
        e_trap         = 1'b1;
      end
    end else begin
      t_live = 1'b0;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int  n;
    bit  busy;
    n    = 0;
    busy = rq_act[0] || rq_act[1] || rq_cool[0] || rq_cool[1] || t_live;
    while (busy && n < max_cycles) begin
      step();
      n++;
      busy = rq_act[0] || rq_act[1] || rq_cool[0] || rq_cool[1] || t_live;
    end
    check_eq("drain_bound", busy, 1'b0);
  endtask

  task automatic clear_obs();
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    rdy_cyc[0] = -1;
    rdy_cyc[1] = -1;
    acc_obs    = 0;
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    rq_act[0]  = 1'b0;
    rq_act[1]  = 1'b0;
    rq_cool[0] = 1'b0;
    rq_cool[1] = 1'b0;
    i_valid    = 1'b0;
    d_valid    = 1'b0;
    mem_ready  = 1'b0;
    acc_seen   = 0;
    model_reset();
    @(posedge clock);
    #1;
    check_eq("rst_mem_valid", mem_valid, 1'b0);
    check_eq("rst_mem_instr", mem_instr, 1'b0);
    check_eq("rst_mem_addr", mem_addr, ProgAddr);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_mem_wstrb", mem_wstrb, 4'h0);
    check_eq("rst_readies", {i_ready, d_ready}, 2'b00);
    check_eq("rst_errs", {i_err, d_err}, 2'b00);
    check_eq("rst_i_rdata", i_rdata, 32'h0);
    check_eq("rst_d_rdata", d_rdata, 32'h0);
    check_eq("rst_trap", trap, 1'b0);
    resetn = 1'b1;
  endtask

  initial begin
    int c0;
    resetn       = 1'b0;
    i_addr       = '0;
    d_addr       = '0;
    d_wdata      = '0;
    d_wstrb      = '0;
    mem_rdata    = '0;
    d_wdata_v    = '0;
    d_wstrb_v    = '0;
    rq_addr[0]   = '0;
    rq_addr[1]   = '0;
    noise        = 1'b0;
    mem_force    = 0;
    mem_wait     = 0;
    rdata_fix_en = 1'b0;
    rdata_fix    = '0;
    both_rdy     = 0;
    cyc          = 0;
    clear_obs();
    #1;
    do_reset();

    // Lone fetch, ready on the second ACCESS cycle: grant + 2 ACCESS + RESP = 4 cycles.
    mem_force    = 1;
    rdata_fix_en = 1'b1;
    rdata_fix    = 32'h0000_0013;
    clear_obs();
    c0 = cyc;
    request(0, 32'h0001_0000, '0, '0);
    drain(20);
    check_eq("fetch_latency", rdy_cyc[0] - c0 + 1, 4);
    check_eq("fetch_pulses", rdy_cnt[0], 1);
    check_eq("fetch_rdata", i_rdata, 32'h0000_0013);
    check_eq("fetch_err", i_err, 1'b0);
    check_eq("fetch_instr", obs_instr, 1'b1);
    rdata_fix_en = 1'b0;

    // Data write with immediate mem_ready: minimum 3-cycle latency.
    mem_force = 0;
    clear_obs();
    c0 = cyc;
    request(1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011);
    drain(20);
    check_eq("wr_addr", obs_addr, 32'h0000_2000);
    check_eq("wr_wdata", obs_wdata, 32'hDEAD_BEEF);
    check_eq("wr_wstrb", obs_wstrb, 4'b0011);
    check_eq("wr_instr", obs_instr, 1'b0);
    check_eq("wr_pulses", rdy_cnt[1], 1);
    check_eq("wr_latency", rdy_cyc[1] - c0 + 1, 3);

    // Simultaneous requests after reset alternate I, D, I, D.
    do_reset();
    gnt_log.delete();
    mem_force = 1;
    for (int r = 0; r < 2; r++) begin
      request(0, $urandom(), '0, '0);
      request(1, $urandom(), $urandom(), 4'($urandom_range(0, 15)));
      drain(40);
    end
    check_eq("rr_count", gnt_log.size(), 4);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++) begin
      check_eq($sformatf("rr_grant%0d", k), gnt_log[k], k % 2);
    end

    // Memory never responds: 15 ACCESS cycles then an error response and sticky trap.
    mem_force = 1000;
    clear_obs();
    request(1, 32'h0000_3000, 32'h1234_5678, 4'b0000);
    drain(40);
    check_eq("to_access_cycles", acc_obs, Timeout);
    check_eq("to_d_err", d_err, 1'b1);
    check_eq("to_d_rdata", d_rdata, 32'h0);
    check_eq("to_trap", trap, 1'b1);
    mem_force = 0;
    request(0, 32'h0000_0040, '0, '0);
    drain(20);
    check_eq("trap_sticky", trap, 1'b1);
    check_eq("after_trap_i_err", i_err, 1'b0);

    // mem_ready on the cycle the timeout would fire: response wins, no trap.
    do_reset();
    mem_force = Timeout - 1;
    clear_obs();
    request(0, 32'h0000_0080, '0, '0);
    drain(40);
    check_eq("edge_access_cycles", acc_obs, Timeout);
    check_eq("edge_i_err", i_err, 1'b0);
    check_eq("edge_trap", trap, 1'b0);

    // Requester abandons valid after the grant: response still pulsed once.
    mem_force = 2;
    clear_obs();
    request(1, 32'h0000_0100, 32'hA5A5_5A5A, 4'b1111);
    step();
    rq_act[1] = 1'b0;
    drain(20);
    check_eq("abandon_pulses", rdy_cnt[1], 1);

    // Reset asserted during ACCESS: port drops at once, no stale response afterwards.
    mem_force = 1000;
    request(0, 32'h0000_0200, '0, '0);
    step();
    step();
    step();
    #2;
    resetn = 1'b0;
    #1;
    check_eq("async_mem_valid", mem_valid, 1'b0);
    check_eq("async_readies", {i_ready, d_ready}, 2'b00);
    model_reset();
    rq_act[0]  = 1'b0;
    rq_act[1]  = 1'b0;
    rq_cool[0] = 1'b0;
    rq_cool[1] = 1'b0;
    acc_seen   = 0;
    mem_ready  = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    clear_obs();
    for (int k = 0; k < 3; k++) step();
    check_eq("abort_no_ready", rdy_cnt[0] + rdy_cnt[1], 0);
    gnt_log.delete();
    mem_force = 0;
    request(0, 32'h0000_0300, '0, '0);
    request(1, 32'h0000_0304, 32'h0BAD_F00D, 4'b0100);
    drain(40);
    check_eq("post_abort_grants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check_eq("post_abort_first", gnt_log[0], 0);
      check_eq("post_abort_second", gnt_log[1], 1);
    end

    // Randomized traffic with stray mem_ready outside ACCESS.
    do_reset();
    noise     = 1'b1;
    mem_force = -1;
    for (int k = 0; k < 1500; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!rq_act[r] && !rq_cool[r] && $urandom_range(0, 3) == 0) begin
          request(r, $urandom(), $urandom(), 4'($urandom_range(0, 15)));
        end
      end
      step();
    end
    drain(60);
    check_eq("never_dual_ready", both_rdy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
